hazard_ctrl: RTL

- Stall/forward controller for the 5-stage pipeline.
- Keeps a registered shadow scoreboard of the E, M and W stage destinations and their remaining Tnew, and compares each D-stage instruction's sources against it.
- Drives the IF/ID register enable and PC enable through `stall`, the D/E register clear through `flush_e`, and the D-stage forwarding muxes.
- Also sequences the optional mult/div busy interlock.

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline: shadow E/M/W scoreboard vs D-stage sources.
// Optional mult/div busy interlock is compiled in when MULTDIV_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wreg,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic [4:0] e_wreg,
  output logic [4:0] m_wreg
`ifdef MULTDIV_EN
  ,
  input  logic       d_md,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       md_busy
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  if (MULT_CYCLES == 0 || DIV_CYCLES == 0 || MULT_CYCLES > 255 || DIV_CYCLES > 255) begin : g_bad_cycles
    $error("hazard_ctrl: MULT_CYCLES and DIV_CYCLES must be in 1..255");
  end

  slot_t            e_q;
  slot_t            m_q;
  logic [REG_W-1:0] w_wreg_q;   // W has already produced its value, so its tnew is implicitly 0

  logic             stall_rs;
  logic             stall_rt;
  logic             md_stall;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x != '0) ? x - TNEW_W'(1) : '0;
  endfunction

  // Youngest-match lookup for one source: returns {stall, fwd_sel}.
  function automatic logic [2:0] resolve(
    input logic [REG_W-1:0]  src,
    input logic [1:0]        tuse,
    input slot_t             e,
    input slot_t             m,
    input logic [REG_W-1:0]  w
  );
    logic              found;
    logic [1:0]        sel;
    logic [TNEW_W-1:0] tnew;
    logic              hold;
    logic [1:0]        fwd;
    found = 1'b0;
    sel   = FWD_GRF;
    tnew  = '0;
    if (src != '0) begin
      if (e.wreg == src) begin
        found = 1'b1;
        sel   = FWD_E;
        tnew  = e.tnew;
      end else if (m.wreg == src) begin
        found = 1'b1;
        sel   = FWD_M;
        tnew  = m.tnew;
      end else if (w == src) begin
        found = 1'b1;
        sel   = FWD_W;
        tnew  = '0;
      end
    end
    hold = found && (tuse != TUSE_NONE) && (tnew > tuse);
    fwd  = (found && (tnew == '0)) ? sel : FWD_GRF;
    return {hold, fwd};
  endfunction

  // Hazard decode is purely combinational so the stall lands in the same cycle D presents.
  always_comb begin
    logic [2:0] res_rs;
    logic [2:0] res_rt;
    res_rs   = resolve(d_rs, d_tuse_rs, e_q, m_q, w_wreg_q);
    res_rt   = resolve(d_rt, d_tuse_rt, e_q, m_q, w_wreg_q);
    stall_rs = res_rs[2];
    stall_rt = res_rt[2];
    fwd_rs   = res_rs[1:0];
    fwd_rt   = res_rt[1:0];
    stall    = stall_rs | stall_rt | md_stall;
    flush_e  = stall_rs | stall_rt | md_stall;
    e_wreg   = e_q.wreg;
    m_wreg   = m_q.wreg;
  end

  // Scoreboard advance; a stall drops a bubble into E, mirroring the D/E flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_wreg_q <= '0;
    end else begin
      w_wreg_q <= m_q.wreg;
      m_q      <= {e_q.wreg, sat_dec(e_q.tnew)};
      e_q      <= stall ? '0 : {d_wreg, d_tnew};
    end
  end

`ifdef MULTDIV_EN
  localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MD_MAX + 1);

  logic [CNT_W-1:0] md_cnt;

  // Busy down-counter; a fresh start always reloads even if still counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (e_md_start) begin
      md_cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_md & (md_busy | e_md_start);
`else
  assign md_stall = 1'b0;
`endif

endmodule
